// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one shared ALU, one req/ready memory port, internal register file.
// Optional performance counters are compiled in when MIPS_PERF_CNT_EN is defined.
module mips_multicycle_core #(
  parameter int            AW       = 6,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            CNT_W    = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [AW-1:0]    pc,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ins_cnt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0]   regs_q [32];
  logic          mem_req_q, mem_we_q, halted_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic [5:0]    op, funct;
  logic [4:0]    rs, rt, rd;
  logic [31:0]   simm, alu_res, mem_ea;
  logic [AW-1:0] pc_inc, br_tgt;
  logic          is_sw;
  state_e        dispatch;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_inc = pc_q + AW'(1);
  assign mem_ea = a_q + simm;
  assign is_sw  = (op == 6'h2B);
  // The branch target was precomputed into alu_q during DECODE.
  assign br_tgt = (a_q == b_q) ? alu_q[AW-1:0] : pc_q;

  always_comb begin
    alu_res = '0;
    case (funct)
      6'h20:   alu_res = a_q + b_q;
      6'h22:   alu_res = a_q - b_q;
      6'h24:   alu_res = a_q & b_q;
      6'h25:   alu_res = a_q | b_q;
      6'h2A:   alu_res = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    dispatch = S_HALT;
    case (op)
      6'h00:        if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) dispatch = S_EXEC;
      6'h23, 6'h2B: dispatch = S_MEMADR;
      6'h04:        dispatch = S_BRANCH;
      6'h08:        dispatch = S_ADDIEX;
      6'h02:        dispatch = S_JUMP;
      default:      dispatch = S_HALT;
    endcase
  end

  // Memory outputs are launched on the edge entering a requesting state, so a
  // transfer with mem_ready high completes in that state's first cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ready) begin
            ir_q      <= mem_rdata;
            pc_q      <= pc_inc;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q      <= regs_q[rs];
          b_q      <= regs_q[rt];
          alu_q    <= {{(32-AW){1'b0}}, pc_q} + simm;
          halted_q <= (dispatch == S_HALT);
          state_q  <= dispatch;
        end
        S_MEMADR: begin
          alu_q       <= mem_ea;
          mem_req_q   <= 1'b1;
          mem_we_q    <= is_sw;
          mem_addr_q  <= mem_ea[AW-1:0];
          mem_wdata_q <= b_q;
          state_q     <= is_sw ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mdr_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= S_MEMWB;
          end
        end
        S_MEMWB: begin
          if (rt != 5'd0) regs_q[rt] <= mdr_q;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
          state_q    <= S_FETCH;
        end
        S_MEMWR: begin
          if (mem_ready) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
            state_q    <= S_FETCH;
          end
        end
        S_EXEC: begin
          alu_q   <= alu_res;
          state_q <= S_ALUWB;
        end
        S_ALUWB: begin
          if (rd != 5'd0) regs_q[rd] <= alu_q;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
          state_q    <= S_FETCH;
        end
        S_ADDIEX: begin
          alu_q   <= mem_ea;
          state_q <= S_ADDIWB;
        end
        S_ADDIWB: begin
          if (rt != 5'd0) regs_q[rt] <= alu_q;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
          state_q    <= S_FETCH;
        end
        S_BRANCH: begin
          pc_q       <= br_tgt;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= br_tgt;
          state_q    <= S_FETCH;
        end
        S_JUMP: begin
          pc_q       <= ir_q[AW-1:0];
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= ir_q[AW-1:0];
          state_q    <= S_FETCH;
        end
        default: begin
          mem_req_q <= 1'b0;
          halted_q  <= 1'b1;
          state_q   <= S_HALT;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

`ifdef MIPS_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             retire;

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_ADDIWB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retire) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`else
  assign cyc_cnt = '0;
  assign ins_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: an instruction-level reference model predicts
// every memory transfer; a monitor compares each completed transfer against the queue.
module tb_mips_multicycle_core;

  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int CNT_W = 32;
  localparam logic [31:0] HALT_INS = 32'hFC00_0000;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             mem_req, mem_we, mem_ready;
  logic [AW-1:0]    mem_addr, pc;
  logic [31:0]      mem_wdata, mem_rdata;
  logic             halted;
  logic [CNT_W-1:0] cyc_cnt, ins_cnt;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            t;
  } xfer_t;

  logic [31:0] mem     [DEPTH];
  logic [31:0] initMem [DEPTH];
  xfer_t       expQ[$];

  int checks = 0, passes = 0, fails = 0;
  int readyMode = 0, edgeCnt = 0, baseEdge = 0, runCycles = 0;
  int modelPc = 0, modelRetired = 0;
  bit monEn = 1'b0, timedRun = 1'b0, haveBase = 1'b0, stallPrev = 1'b0;
  logic          pWe;
  logic [AW-1:0] pAddr;
  logic [31:0]   pWdata;

  mips_multicycle_core #(.AW(AW), .RESET_PC(6'd0), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .halted(halted), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Edge bookkeeping: absolute edge index for latency checks, cycles since reset release.
  always @(posedge clk) begin
    edgeCnt++;
    if (clr_n) runCycles++;
  end

  // Memory wait-state generator: mode 0 never stalls, mode 1 stalls randomly, mode 2 is manual.
  always @(posedge clk) begin
    #1;
    if (readyMode == 0) mem_ready = 1'b1;
    else if (readyMode == 1) mem_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: at each negedge, a pending req with ready completes at the next posedge.
  // It checks stall stability, pops the scoreboard, then performs the memory write.
  always @(negedge clk) begin
    xfer_t e;
    if (monEn && clr_n) begin
      if (stallPrev) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== pWe || mem_addr !== pAddr || (pWe && mem_wdata !== pWdata)) begin
          fails++;
          $display("[TB] FAIL holdStable: req=%0b we=%0b addr=%0d wdata=%h, required req=1 we=%0b addr=%0d wdata=%h",
                   mem_req, mem_we, mem_addr, mem_wdata, pWe, pAddr, pWdata);
        end else passes++;
      end
      stallPrev = mem_req && !mem_ready;
      pWe       = mem_we;
      pAddr     = mem_addr;
      pWdata    = mem_wdata;
      if (mem_req && mem_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpectedXfer: we=%0b addr=%0d, required no transfer", mem_we, mem_addr);
        end else begin
          e = expQ.pop_front();
          if (!haveBase) begin
            baseEdge = edgeCnt;
            haveBase = 1'b1;
          end
          if (mem_we !== e.we || mem_addr !== e.addr ||
              (e.we ? (mem_wdata !== e.data) : (mem_rdata !== e.data)) ||
              (timedRun && (edgeCnt - baseEdge) != e.t)) begin
            fails++;
            $display("[TB] FAIL xfer: we=%0b addr=%0d data=%h edge=%0d, required we=%0b addr=%0d data=%h edge=%0d",
                     mem_we, mem_addr, e.we ? mem_wdata : mem_rdata, edgeCnt - baseEdge,
                     e.we, e.addr, e.data, e.t);
          end else passes++;
        end
      end
    end
    if (clr_n && mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
  end

  function automatic logic [31:0] rType(int rs, int rt, int rd, logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction

  function automatic logic [31:0] iType(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] jType(int target);
    return {6'h02, 26'(target)};
  endfunction

  function automatic void pushX(logic we, int addr, logic [31:0] data, int t);
    xfer_t x;
    x.we   = we;
    x.addr = AW'(addr);
    x.data = data;
    x.t    = t;
    expQ.push_back(x);
  endfunction

  // Reference model: executes the program one instruction at a time and predicts every
  // transfer with its edge offset (latencies lw 5, sw/R/addi 4, beq/j 3 without wait states).
  task automatic runModel();
    logic [31:0] mm [DEPTH];
    logic [31:0] r [32];
    logic [31:0] ins, a, b, imm, res;
    int p, t, ea;
    bit stop;
    for (int i = 0; i < DEPTH; i++) mm[i] = initMem[i];
    for (int i = 0; i < 32; i++) r[i] = '0;
    p = 0; t = 0; stop = 1'b0; modelRetired = 0;
    for (int n = 0; n < 1000 && !stop; n++) begin
      ins = mm[p];
      pushX(1'b0, p, ins, t);
      p   = (p + 1) % DEPTH;
      a   = r[ins[25:21]];
      b   = r[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      res = '0;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: stop = 1'b1;
          endcase
          if (!stop) begin
            r[ins[15:11]] = res;
            t += 4;
          end
        end
        6'h08: begin
          r[ins[20:16]] = a + imm;
          t += 4;
        end
        6'h23: begin
          ea = int'((a + imm) & 32'h3F);
          pushX(1'b0, ea, mm[ea], t + 3);
          r[ins[20:16]] = mm[ea];
          t += 5;
        end
        6'h2B: begin
          ea = int'((a + imm) & 32'h3F);
          pushX(1'b1, ea, b, t + 3);
          mm[ea] = b;
          t += 4;
        end
        6'h04: begin
          if (a == b) p = int'((32'(p) + imm) & 32'h3F);
          t += 3;
        end
        6'h02: begin
          p = int'(ins & 32'h3F);
          t += 3;
        end
        default: stop = 1'b1;
      endcase
      r[0] = '0;
      if (!stop) modelRetired++;
    end
    modelPc = p;
  endtask

  task automatic clearInit();
    for (int i = 0; i < DEPTH; i++) initMem[i] = '0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else passes++;
  endtask

  // Reset the core, load memory, predict the run and release reset.
  task automatic applyStimulus(input int mode);
    monEn     = 1'b0;
    clr_n     = 1'b0;
    readyMode = mode;
    mem_ready = (mode == 0);
    timedRun  = (mode == 0);
    haveBase  = 1'b0;
    stallPrev = 1'b0;
    expQ.delete();
    for (int i = 0; i < DEPTH; i++) mem[i] = initMem[i];
    runModel();
    repeat (2) @(negedge clk);
    runCycles = 0;
    monEn     = 1'b1;
    clr_n     = 1'b1;
  endtask

  // Wait (bounded) for every predicted transfer plus halt, then check the final state.
  task automatic checkOutput(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (expQ.size() == 0 && halted) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL %s timeout: %0d transfers outstanding, halted=%0b, required 0 and 1",
               name, expQ.size(), halted);
    end else passes++;
    repeat (3) @(negedge clk);
    checkVal({name, " halted"}, {31'b0, halted}, 32'd1);
    checkVal({name, " reqIdle"}, {31'b0, mem_req}, 32'd0);
    checkVal({name, " pc"}, {26'b0, pc}, 32'(modelPc));
`ifdef MIPS_PERF_CNT_EN
    checkVal({name, " insCnt"}, ins_cnt, 32'(modelRetired));
    checkVal({name, " cycCnt"}, cyc_cnt, 32'(runCycles));
`else
    checkVal({name, " insCnt"}, ins_cnt, 32'd0);
    checkVal({name, " cycCnt"}, cyc_cnt, 32'd0);
`endif
  endtask

  task automatic genRandom();
    logic [5:0] fl [5];
    int r, imm;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clearInit();
    for (int i = 48; i < DEPTH; i++) initMem[i] = $urandom;
    for (int i = 0; i < 12; i++) begin
      r   = int'($urandom_range(0, 9));
      imm = 48 + int'($urandom_range(0, 15)) + 64 * int'($urandom_range(0, 3));
      case (r)
        0, 1, 2: initMem[i] = rType(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                    int'($urandom_range(0, 7)), fl[$urandom_range(0, 4)]);
        3, 4, 9: initMem[i] = iType(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(1, 7)),
                                    int'($urandom_range(0, 65535)));
        5:       initMem[i] = iType(6'h23, 0, int'($urandom_range(1, 7)), imm);
        6:       initMem[i] = iType(6'h2B, 0, int'($urandom_range(0, 7)), imm);
        7:       initMem[i] = iType(6'h04, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                    int'($urandom_range(0, 11 - i)));
        default: initMem[i] = jType(int'($urandom_range(i + 1, 12)));
      endcase
    end
    for (int k = 1; k <= 7; k++) initMem[11 + k] = iType(6'h2B, 0, k, 56 + k);
    initMem[19] = HALT_INS;
  endtask

  initial begin
    bit found;
    clr_n     = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("resetReq",   {31'b0, mem_req}, 32'd0);
    checkVal("resetWe",    {31'b0, mem_we},  32'd0);
    checkVal("resetAddr",  {26'b0, mem_addr}, 32'd0);
    checkVal("resetWdata", mem_wdata, 32'd0);
    checkVal("resetPc",    {26'b0, pc}, 32'd0);
    checkVal("resetHalt",  {31'b0, halted}, 32'd0);

    $display("[TB] arithmetic program");
    clearInit();
    initMem[0] = iType(6'h08, 0, 1, 5);
    initMem[1] = iType(6'h08, 0, 2, -3);
    initMem[2] = rType(1, 2, 3, 6'h20);
    initMem[3] = rType(2, 1, 4, 6'h2A);
    initMem[4] = iType(6'h2B, 0, 3, 60);
    initMem[5] = iType(6'h2B, 0, 4, 61);
    initMem[6] = HALT_INS;
    applyStimulus(0);
    checkOutput("arith");
    checkVal("arith sum", mem[60], 32'd2);
    checkVal("arith slt", mem[61], 32'd1);

    $display("[TB] store/load program");
    clearInit();
    initMem[0] = iType(6'h08, 0, 1, 32'h1234);
    initMem[1] = iType(6'h2B, 0, 1, 8);
    initMem[2] = iType(6'h23, 0, 5, 8);
    initMem[3] = iType(6'h2B, 0, 5, 9);
    initMem[4] = rType(0, 0, 0, 6'h21);
    applyStimulus(0);
    checkOutput("swlw");
    checkVal("swlw mem8", mem[8], 32'h1234);
    checkVal("swlw mem9", mem[9], 32'h1234);

    $display("[TB] branch and jump program with wait states");
    clearInit();
    initMem[0]  = iType(6'h08, 1, 1, 1);
    initMem[1]  = iType(6'h08, 0, 2, 1);
    initMem[2]  = iType(6'h08, 9, 9, 1);
    initMem[3]  = iType(6'h04, 1, 2, -4);
    initMem[4]  = jType(42);
    initMem[42] = iType(6'h2B, 0, 1, 50);
    initMem[43] = iType(6'h2B, 0, 9, 51);
    initMem[44] = HALT_INS;
    applyStimulus(1);
    checkOutput("branch");
    checkVal("branch r1", mem[50], 32'd2);
    checkVal("branch loops", mem[51], 32'd2);

    $display("[TB] reset during load");
    clearInit();
    initMem[0]  = iType(6'h08, 0, 5, 7);
    initMem[1]  = iType(6'h23, 0, 6, 40);
    initMem[2]  = HALT_INS;
    initMem[40] = 32'hCAFE;
    monEn = 1'b0;
    clr_n = 1'b0;
    readyMode = 2;
    mem_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = initMem[i];
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 6'd40) begin
        found = 1'b1;
        break;
      end
    end
    mem_ready = 1'b0;
    checkVal("lwReqSeen", {31'b0, found}, 32'd1);
    repeat (2) @(negedge clk);
    checkVal("lwStallReq", {31'b0, mem_req}, 32'd1);
    #2 clr_n = 1'b0;
    #1;
    checkVal("midResetReq",  {31'b0, mem_req}, 32'd0);
    checkVal("midResetPc",   {26'b0, pc}, 32'd0);
    checkVal("midResetAddr", {26'b0, mem_addr}, 32'd0);
    checkVal("midResetHalt", {31'b0, halted}, 32'd0);
    clearInit();
    initMem[0] = iType(6'h2B, 0, 5, 50);
    initMem[1] = iType(6'h2B, 0, 6, 51);
    initMem[2] = HALT_INS;
    @(negedge clk);
    applyStimulus(0);
    checkOutput("postReset");
    checkVal("postReset r5", mem[50], 32'd0);
    checkVal("postReset r6", mem[51], 32'd0);

    $display("[TB] randomized programs");
    for (int k = 0; k < 8; k++) begin
      genRandom();
      applyStimulus(k % 2);
      checkOutput("random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle successor to the single-cycle MIPS datapath.
- Shares one ALU and one memory port across instruction phases under an FSM controller.
- Talks to a single unified instruction/data memory through a req/ready handshake, so memory may insert wait states.
- Sits between the testbench/top and a shared memory model; the register file is internal.

Parameters:
- AW, 6, word-address width of PC and memory bus (memory depth 2^AW words of 32 bits)
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  AW  word address
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data; valid when mem_ready=1
- mem_ready  in  1  transfer completes at a rising edge where mem_req=1 and mem_ready=1
- pc  out  AW  current PC
- halted  out  1  core stopped on an unsupported opcode
- cyc_cnt  out  CNT_W  cycles since reset (optional feature)
- ins_cnt  out  CNT_W  retired instructions (optional feature)

Behaviour:
- Reset (clr_n=0, async):
  - pc=RESET_PC; all 32 registers = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - FSM=FETCH.
  - Deassertion is sampled on the next rising edge.
- Word addressing: PC+1 per instruction. Addresses truncate to AW bits and wrap modulo 2^AW.
- Supported instructions: R-type (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Register 0 reads as 0; writes to it are discarded.
- Immediates are sign-extended from 16 to 32 bits.
- ALU results wrap modulo 2^32. slt is a signed compare.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the completing edge.
  - The FSM stalls in the requesting state while mem_ready=0.
  - mem_req drops in the cycle after completion.
  - mem_ready is ignored while mem_req=0.
- FSM states and transitions:
  - FETCH: req read at pc. On completion: IR<=rdata, pc<=pc+1, go to DECODE.
  - DECODE: read rs/rt into A/B; compute ALUOut = pc + signimm (branch target). Dispatch by opcode; unsupported opcode or funct goes to HALT.
  - MEMADR: ALUOut = A + signimm. lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD: read req at ALUOut[AW-1:0]. On completion: MDR<=rdata, go to MEMWB.
  - MEMWB: rt<=MDR, go to FETCH.
  - MEMWR: write req, wdata=B. On completion go to FETCH.
  - EXEC: ALUOut = A op B, go to ALUWB.
  - ALUWB: rd<=ALUOut, go to FETCH.
  - ADDIEX: ALUOut = A + signimm, go to ADDIWB.
  - ADDIWB: rt<=ALUOut, go to FETCH.
  - BRANCH: if A==B, pc<=ALUOut. Go to FETCH.
  - JUMP: pc<=IR[AW-1:0], go to FETCH.
  - HALT: halted=1, no requests. Only reset exits.
- Latency with mem_ready tied high:
  - lw 5 cycles
  - sw 4 cycles
  - R-type 4 cycles
  - addi 4 cycles
  - beq 3 cycles
  - j 3 cycles
  - Each wait cycle adds 1.
- Reset mid-transfer: mem_req drops immediately (async). Any partial instruction is abandoned with no register or PC side effects.
- beq uses the already-incremented pc, so target = old_pc + 1 + signimm.

Optional Feature:
- Macro: MIPS_PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every cycle after reset, including stall and HALT cycles, and wraps modulo 2^CNT_W.
  - ins_cnt increments on the final-state edge of each completed instruction (MEMWB, MEMWR completion, ALUWB, ADDIWB, BRANCH, JUMP).
  - Both counters reset to 0.
- Not defined: cyc_cnt and ins_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1, with mem_ready=1 -> after 16 cycles $3=2, $4=1, pc=4.
- sw $1,8($0) then lw $5,8($0), with $1=0x1234 -> mem[8]=0x1234 and $5=0x1234 after 9 cycles; mem_we=1 only during the sw transfer.
- beq taken: $1==$2 at pc=3 with imm=-4 -> next fetch at address 0. beq not taken -> next fetch at 4. j 0x2A -> pc=0x2A.
- mem_ready held low 3 cycles during FETCH -> mem_addr/mem_req stable across the stall; instruction completes 3 cycles later; IR correct.
- Opcode 0x3F fetched -> halted=1 after DECODE, mem_req stays 0. clr_n pulsed low mid-lw -> mem_req=0 immediately, pc=RESET_PC, registers cleared.
- MIPS_PERF_CNT_EN set, 4-instruction program from the first scenario -> ins_cnt=4, cyc_cnt=16 at completion. Not set -> both read 0.
